// File: rtl/calculadora_sec.sv
// calculadora_sec: button-driven registered ALU.
// Rising edges on boton_a / boton_b / boton_op load operand A, operand B and the
// opcode from the shared bus 'entrada'. An opcode load starts a one-cycle
// calculation whose result and flags are registered and announced by 'valido'.
// Buttons are assumed already synchronised to clk.
//
// Optional feature: define ACUMULADOR_EN to write every valid result back into
// operand A, so operations can be chained with only boton_b / boton_op.
module calculadora_sec #(
  parameter int unsigned b_dat = 8,  // data/operand width, >= 2
  parameter int unsigned b_op  = 6   // opcode width, <= b_dat
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [b_dat-1:0] entrada,
  input  logic             boton_a,
  input  logic             boton_b,
  input  logic             boton_op,
  output logic [b_dat-1:0] rdo,
  output logic             carry,
  output logic             zero,
  output logic             error,
  output logic             valido,
  output logic             ocupado
);

  // Opcode map (MIPS funct-style encodings).
  localparam logic [b_op-1:0] OpAdd = b_op'(6'b100000);
  localparam logic [b_op-1:0] OpSub = b_op'(6'b100010);
  localparam logic [b_op-1:0] OpAnd = b_op'(6'b100100);
  localparam logic [b_op-1:0] OpOr  = b_op'(6'b100101);
  localparam logic [b_op-1:0] OpXor = b_op'(6'b100110);
  localparam logic [b_op-1:0] OpNor = b_op'(6'b100111);
  localparam logic [b_op-1:0] OpSrl = b_op'(6'b000010);
  localparam logic [b_op-1:0] OpSra = b_op'(6'b000011);

  // Shift amounts at or above this saturate; b_dat always fits in b_dat bits.
  localparam logic [b_dat-1:0] AnchoDat = b_dat'(b_dat);

  typedef enum logic {StReposo, StCalculo} estado_t;

  estado_t state_q, state_d;

  // Operand and opcode registers.
  logic [b_dat-1:0] a_q, b_q;
  logic [b_op-1:0]  op_q;

  // Button edge detection.
  logic prev_a, prev_b, prev_op;
  logic edge_a, edge_b, edge_op;

  // Load strobes decoded from the FSM.
  logic ld_a, ld_b, ld_op, ld_res;

  // Combinational ALU results.
  logic [b_dat-1:0] alu_rdo;
  logic             alu_carry;
  logic             alu_err;
  logic [b_dat:0]   suma, resta;

  // Button history; loading the live level during reset suppresses edges from
  // buttons held through reset.
  always_ff @(posedge clk) begin
    prev_a  <= boton_a;
    prev_b  <= boton_b;
    prev_op <= boton_op;
  end

  assign edge_a  = boton_a  & ~prev_a;
  assign edge_b  = boton_b  & ~prev_b;
  assign edge_op = boton_op & ~prev_op;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReposo;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: an opcode edge starts a single calculation cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReposo:  if (edge_op) state_d = StCalculo;
      StCalculo: state_d = StReposo;
    endcase
  end

  // FSM outputs: loads only happen in REPOSO, so edges during CALCULO are lost.
  always_comb begin
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_res  = 1'b0;
    ocupado = (state_q == StCalculo);
    unique case (state_q)
      StReposo: begin
        ld_a  = edge_a;
        ld_b  = edge_b;
        ld_op = edge_op;
      end
      StCalculo: ld_res = 1'b1;
    endcase
  end

  // ALU: pure function of the registered operands and opcode.
  always_comb begin
    suma      = {1'b0, a_q} + {1'b0, b_q};
    resta     = {1'b0, a_q} - {1'b0, b_q};
    alu_rdo   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_rdo   = suma[b_dat-1:0];
        alu_carry = suma[b_dat];
      end
      OpSub: begin
        // Top bit of the widened difference is the borrow (A < B unsigned).
        alu_rdo   = resta[b_dat-1:0];
        alu_carry = resta[b_dat];
      end
      OpAnd: alu_rdo = a_q & b_q;
      OpOr:  alu_rdo = a_q | b_q;
      OpXor: alu_rdo = a_q ^ b_q;
      OpNor: alu_rdo = ~(a_q | b_q);
      OpSrl: begin
        if (b_q >= AnchoDat) alu_rdo = '0;
        else                 alu_rdo = a_q >> b_q;
      end
      OpSra: begin
        if (b_q >= AnchoDat) alu_rdo = {b_dat{a_q[b_dat-1]}};
        else                 alu_rdo = $unsigned($signed(a_q) >>> b_q);
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Datapath registers: operands, opcode, result and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      rdo    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
      error  <= 1'b0;
      valido <= 1'b0;
    end else begin
      valido <= ld_res;
      if (ld_a)  a_q  <= entrada;
      if (ld_b)  b_q  <= entrada;
      if (ld_op) op_q <= entrada[b_op-1:0];
      if (ld_res) begin
        rdo   <= alu_rdo;
        carry <= alu_carry;
        zero  <= (alu_rdo == '0);
        error <= alu_err;
`ifdef ACUMULADOR_EN
        // ld_a and ld_res are never both set, so an A edge still wins in REPOSO.
        if (!alu_err) a_q <= alu_rdo;
`endif
      end
    end
  end

endmodule

// File: tb/tb_calculadora_sec.sv
// Directed testbench for calculadora_sec (default parameters b_dat=8, b_op=6).
module tb_calculadora_sec;

  logic       clk;
  logic       reset;
  logic [7:0] entrada;
  logic       boton_a, boton_b, boton_op;
  logic [7:0] rdo;
  logic       carry, zero, error, valido, ocupado;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  calculadora_sec #(.b_dat(8), .b_op(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .entrada  (entrada),
    .boton_a  (boton_a),
    .boton_b  (boton_b),
    .boton_op (boton_op),
    .rdo      (rdo),
    .carry    (carry),
    .zero     (zero),
    .error    (error),
    .valido   (valido),
    .ocupado  (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_a(input logic [7:0] v);
    entrada = v;
    boton_a = 1'b1;
    tick();
    boton_a = 1'b0;
    tick();
  endtask

  task automatic press_b(input logic [7:0] v);
    entrada = v;
    boton_b = 1'b1;
    tick();
    boton_b = 1'b0;
    tick();
  endtask

  // Op edge seen at the first edge, busy for one cycle, result at the second.
  task automatic run_op(input string tag, input logic [5:0] opc);
    entrada  = {2'b00, opc};
    boton_op = 1'b1;
    tick();
    check({tag, "_ocupado"}, {31'd0, ocupado}, 32'd1);
    boton_op = 1'b0;
    tick();
    check({tag, "_valido"}, {31'd0, valido}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [7:0] e_rdo, input logic e_carry,
                           input logic e_zero, input logic e_err);
    check({tag, "_rdo"},   {24'd0, rdo},   {24'd0, e_rdo});
    check({tag, "_carry"}, {31'd0, carry}, {31'd0, e_carry});
    check({tag, "_zero"},  {31'd0, zero},  {31'd0, e_zero});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
  endtask

  initial begin
    // Reset with every button held high and a non-zero bus.
    reset    = 1'b1;
    entrada  = 8'hAA;
    boton_a  = 1'b1;
    boton_b  = 1'b1;
    boton_op = 1'b1;
    tick();
    tick();
    check_res("rst", 8'h00, 1'b0, 1'b1, 1'b0);
    check("rst_valido", {31'd0, valido}, 32'd0);
    check("rst_ocupado", {31'd0, ocupado}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valido", {31'd0, valido}, 32'd0);
      check("hold_ocupado", {31'd0, ocupado}, 32'd0);
    end
    boton_a  = 1'b0;
    boton_b  = 1'b0;
    boton_op = 1'b0;
    tick();
    check("rel_valido", {31'd0, valido}, 32'd0);
    // A and B must still be zero: no edge was ever seen.
    run_op("post_rst_add", OP_ADD);
    check_res("post_rst_add", 8'h00, 1'b0, 1'b1, 1'b0);

    // ADD with carry out, plus latency and one-cycle strobe.
    press_a(8'hC8);
    press_b(8'h64);
    run_op("add", OP_ADD);
    check_res("add", 8'h2C, 1'b1, 1'b0, 1'b0);
    tick();
    check("add_valido_drop", {31'd0, valido}, 32'd0);
    check("add_rdo_hold", {24'd0, rdo}, 32'h2C);

    // SUB to zero, then with borrow.
    press_a(8'h05);
    press_b(8'h05);
    run_op("sub0", OP_SUB);
    check_res("sub0", 8'h00, 1'b0, 1'b1, 1'b0);
    press_a(8'h05);
    press_b(8'h06);
    run_op("subb", OP_SUB);
    check_res("subb", 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("subb_hold", {24'd0, rdo}, 32'hFF);
    check("subb_hold_valido", {31'd0, valido}, 32'd0);

    // Shifts with an oversize amount, then a normal amount.
    press_a(8'h80);
    press_b(8'h09);
    run_op("sra9", OP_SRA);
    check_res("sra9", 8'hFF, 1'b0, 1'b0, 1'b0);
    press_a(8'h80);
    run_op("srl9", OP_SRL);
    check_res("srl9", 8'h00, 1'b0, 1'b1, 1'b0);
    press_a(8'h80);
    press_b(8'h01);
    run_op("sra1", OP_SRA);
    check_res("sra1", 8'hC0, 1'b0, 1'b0, 1'b0);
    press_a(8'h80);
    run_op("srl1", OP_SRL);
    check_res("srl1", 8'h40, 1'b0, 1'b0, 1'b0);

    // Unsupported opcode.
    run_op("bad", OP_BAD);
    check_res("bad", 8'h00, 1'b0, 1'b1, 1'b1);

    // Simultaneous A and op edges; B edge during CALCULO is dropped.
    press_b(8'h0F);
    entrada  = 8'h24;
    boton_a  = 1'b1;
    boton_op = 1'b1;
    tick();
    check("and_ocupado", {31'd0, ocupado}, 32'd1);
    boton_a  = 1'b0;
    boton_op = 1'b0;
    boton_b  = 1'b1;
    entrada  = 8'h55;
    tick();
    check("and_valido", {31'd0, valido}, 32'd1);
    check_res("and", 8'h04, 1'b0, 1'b0, 1'b0);
    boton_b = 1'b0;
    tick();
    press_a(8'h00);
    run_op("or_b_kept", OP_OR);
    check_res("or_b_kept", 8'h0F, 1'b0, 1'b0, 1'b0);

    // Remaining logic ops.
    press_a(8'h3C);
    run_op("xor", OP_XOR);
    check_res("xor", 8'h33, 1'b0, 1'b0, 1'b0);
    press_a(8'h3C);
    run_op("nor", OP_NOR);
    check_res("nor", 8'hC0, 1'b0, 1'b0, 1'b0);

    // Chained ADD: accumulates only with the optional feature.
    press_a(8'h03);
    press_b(8'h04);
    run_op("acc1", OP_ADD);
    check_res("acc1", 8'h07, 1'b0, 1'b0, 1'b0);
    run_op("acc2", OP_ADD);
`ifdef ACUMULADOR_EN
    check_res("acc2", 8'h0B, 1'b0, 1'b0, 1'b0);
`else
    check_res("acc2", 8'h07, 1'b0, 1'b0, 1'b0);
`endif

    // Reset during CALCULO: no strobe, reset values win.
    entrada  = {2'b00, OP_ADD};
    boton_op = 1'b1;
    tick();
    check("rstc_ocupado", {31'd0, ocupado}, 32'd1);
    boton_op = 1'b0;
    reset    = 1'b1;
    tick();
    check("rstc_valido", {31'd0, valido}, 32'd0);
    check("rstc_ocupado0", {31'd0, ocupado}, 32'd0);
    check_res("rstc", 8'h00, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    check("rstc_valido_after", {31'd0, valido}, 32'd0);
    check("rstc_ocupado_after", {31'd0, ocupado}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calculadora_sec.md
Name: calculadora_sec

Overview:
Clocked, parametrised successor of the button-driven calculator. Rising edges on three button inputs load operand A, operand B and the opcode from a shared data bus. The opcode load triggers a registered ALU operation. The block returns the result with carry/zero/error flags and a one-cycle valid strobe, and sits between board switches/buttons (already synchronised externally) and the display logic.

Parameters:
b_dat, 8, data/operand width in bits (>=2)
b_op, 6, opcode width in bits; opcode taken from entrada[b_op-1:0] (requires b_op <= b_dat)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
entrada  input  b_dat  shared data/opcode bus
boton_a  input  1  level; rising edge loads A
boton_b  input  1  level; rising edge loads B
boton_op  input  1  level; rising edge loads opcode and starts an operation
rdo  output  b_dat  registered result
carry  output  1  registered carry/borrow flag
zero  output  1  registered, 1 when rdo == 0
error  output  1  registered, 1 when the last opcode was unsupported
valido  output  1  one-cycle pulse when rdo/flags update
ocupado  output  1  high while state == CALCULO

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: registers A, B, op, rdo, carry and error cleared to 0; zero=1; valido=0; ocupado=0; state=REPOSO. Edge-detector history registers are loaded with the current button levels, so a button held through reset produces no edge.
- Edge detect: edge_x = boton_x & ~prev_x; prev_x updates every cycle, including in CALCULO.
- FSM REPOSO:
  - edge_a: A <= entrada.
  - edge_b: B <= entrada.
  - edge_op: op <= entrada[b_op-1:0]; go to CALCULO.
  - Simultaneous edges: all are applied on the same clock. A and B may both take the same entrada value. An op edge coinciding with an A or B edge computes with the newly loaded operand.
- FSM CALCULO (exactly 1 cycle):
  - rdo, carry, zero and error are registered from the ALU.
  - valido <= 1 for one cycle; state returns to REPOSO.
  - All button edges arriving while in CALCULO are dropped, not queued.
- Latency: op edge seen in cycle N; ocupado=1 in cycle N+1; rdo/flags and valido=1 visible in cycle N+2.
- Between operations, rdo and the flags hold their values.
- Opcodes (b_op=6):
  - ADD 100000: {carry,rdo} = A+B, computed at b_dat+1 bits.
  - SUB 100010: rdo = A-B mod 2^b_dat; carry = borrow, i.e. 1 when A<B unsigned.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: carry=0.
  - SRL 000010: rdo = A >> B, logical shift.
  - SRA 000011: rdo = A >>> B, arithmetic shift with A as signed.
  - For both shifts, carry=0. A shift amount B >= b_dat gives 0 for SRL and all-sign-bits for SRA.
  - Any other code: rdo=0, carry=0, error=1. For every valid code, error=0.
- zero is always derived from the new rdo value.
- Reset asserted during CALCULO: the reset values win, no valido pulse is produced, and the state becomes REPOSO.

Optional Feature:
ACUMULADOR_EN:
- Defined: on every completed valid operation (error=0), A <= new rdo in the same clock, so operations can be chained by pressing only boton_b and boton_op. An A edge in REPOSO still overrides A.
- Undefined: A changes only on an A edge or reset.

Test Plan:
- Reset with all buttons high, then release -> no loads; rdo=0, zero=1, valido never pulses.
- A=0xC8, B=0x64, op=100000 -> after 2 cycles: rdo=0x2C, carry=1, zero=0, valido one cycle, ocupado high in cycle N+1.
- A=0x05, B=0x05, op=100010 -> rdo=0x00, zero=1, carry=0. Then B=0x06, op=100010 -> rdo=0xFF, carry=1.
- A=0x80, B=0x09, op=000011 -> rdo=0xFF. Same operands with op=000010 -> rdo=0x00. Op=111111 -> rdo=0, error=1.
- boton_a edge and boton_op edge in the same cycle with entrada=0x24 (A=0x24, op=100100) and B=0x0F -> rdo=0x04. A boton_b edge during CALCULO is dropped: B stays 0x0F.
- ACUMULADOR_EN defined: A=3, B=4, ADD -> rdo=7; then op-edge ADD again -> rdo=0x0B. With the macro undefined, the second ADD -> rdo=7.
